// File: rtl/y_tdm_demux_pkg.sv
// Shared types and defaults for the TDM demultiplexer.
package y_demux_pkg;

    // Frame assembly state: waiting for a frame start, or shifting lanes in.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int LANES_DEF = 8;

endpackage

// File: rtl/y_tdm_demux_if.sv
// Serial-in / parallel-out port bundle of the TDM demultiplexer.
interface y_tdm_demux_if import y_demux_pkg::*; #(
    parameter int LANES = LANES_DEF
);
    logic             in_bit;
    logic             in_valid;
    logic             frame_start;
    logic [LANES-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             busy;

    // Source / consumer side.
    modport master (
        output in_bit, in_valid, frame_start, out_ready,
        input  out_data, out_valid, overrun, busy
    );

    // Demultiplexer side.
    modport slave (
        input  in_bit, in_valid, frame_start, out_ready,
        output out_data, out_valid, overrun, busy
    );
endinterface

// File: rtl/y_tdm_demux_demux1.sv
// 1-to-2 enable demux cell; a tree of these forms the lane-enable decoder.
module y_demux1 (
    input  logic en,
    input  logic sel,
    output logic en0,
    output logic en1
);
    assign en0 = en & ~sel;
    assign en1 = en &  sel;
endmodule

// File: rtl/y_tdm_demux.sv
// Time-division demultiplexer: serial bits steered lane by lane into a
// LANES-wide word, handed out through a one-deep valid/ready buffer.
//
//  state | meaning
//  IDLE  | waiting for a frame_start beat
//  SHIFT | frame in progress, idx_q is the next lane to fill
module y_tdm_demux import y_demux_pkg::*; #(
    parameter int LANES = LANES_DEF,
    parameter int IDX_W = $clog2(LANES)
) (
    input logic           clk,
    input logic           rst_n,
    y_tdm_demux_if.slave  bus
);
    localparam logic [0:0]       S_IDLE  = IDLE;
    localparam logic [0:0]       S_SHIFT = SHIFT;
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(LANES - 1);
    localparam int               LEAF0   = 2 ** IDX_W;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LANES-1:0] shift_q, shift_d;
    logic [LANES-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;

    logic             start;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [LANES-1:0] lane_en;
    logic [LANES-1:0] base;
    logic             complete;

    // Decide whether this beat writes a lane and which one; a frame_start beat
    // always lands in lane 0, otherwise only an active frame accepts bits.
    always_comb begin
        start  = bus.in_valid && bus.frame_start;
        wr_en  = bus.in_valid && (bus.frame_start || (state_q == S_SHIFT));
        wr_idx = start ? '0 : idx_q;
    end

    // Binary tree of 1-to-2 cells: node n feeds children 2n and 2n+1, leaves are lanes.
    logic [2*LEAF0-1:1] en_tree;
    assign en_tree[1] = wr_en;

    for (genvar l = 0; l < IDX_W; l++) begin : g_lvl
        for (genvar k = 0; k < (2 ** l); k++) begin : g_node
            y_demux1 u_cell (
                .en  (en_tree[(2 ** l) + k]),
                .sel (wr_idx[IDX_W-1-l]),
                .en0 (en_tree[2 * ((2 ** l) + k)]),
                .en1 (en_tree[2 * ((2 ** l) + k) + 1])
            );
        end
    end

    assign lane_en = en_tree[LEAF0 + LANES - 1 : LEAF0];

    // FSM, lane write, and the output buffer which runs independently of the FSM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        complete    = 1'b0;
        base        = start ? '0 : shift_q;

        if (wr_en) begin
            shift_d = (base & ~lane_en) | (lane_en & {LANES{bus.in_bit}});
            if (wr_idx == LAST) begin
                complete = 1'b1;
                state_d  = S_IDLE;
                idx_d    = '0;
            end else begin
                state_d  = S_SHIFT;
                idx_d    = wr_idx + 1'b1;
            end
        end

        // A held word is never overwritten; a completion that cannot land is dropped.
        if (complete) begin
            if (!out_valid_q || bus.out_ready) begin
                out_data_d  = shift_d;
                out_valid_d = 1'b1;
            end else begin
                overrun_d   = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any partial frame and any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state_q == S_SHIFT);

endmodule

// File: tb/tb_y_tdm_demux.sv
// Bench for y_tdm_demux with LANES=8: directed vector table, hand-written
// restart/reset sequences, then random traffic against a frame-level model.
module tb_y_tdm_demux;
    localparam int LANES = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    y_tdm_demux_if #(.LANES(LANES)) bus ();

    y_tdm_demux #(.LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    typedef struct {
        int               cnt;    // bits collected in current frame, 0 = no frame
        logic [LANES-1:0] acc;
        logic [LANES-1:0] word;
        logic             wv;
        logic             ovr;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mstep(mdl_t c, logic v, logic fs, logic b, logic rdy);
        mdl_t n    = c;
        logic done = 1'b0;
        n.ovr = 1'b0;
        if (v) begin
            if (fs) begin
                n.acc    = '0;
                n.acc[0] = b;
                n.cnt    = 1;
            end else if (c.cnt > 0) begin
                n.acc[c.cnt] = b;
                n.cnt        = c.cnt + 1;
                if (n.cnt == LANES) begin
                    done  = 1'b1;
                    n.cnt = 0;
                end
            end
        end
        if (done) begin
            if (!c.wv || rdy) begin
                n.word = n.acc;
                n.wv   = 1'b1;
            end else begin
                n.ovr  = 1'b1;
            end
        end else if (c.wv && rdy) begin
            n.wv = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{cnt: 0, acc: '0, word: '0, wv: 1'b0, ovr: 1'b0};
        else        m <= mstep(m, bus.in_valid, bus.frame_start, bus.in_bit, bus.out_ready);
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       v, fs, b, rdy;
        logic       ev;
        logic [7:0] ed;
        logic       eo, eb;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, fs, b, rdy, ev, input logic [7:0] ed, input logic eo, eb);
        vec_t r;
        r.v = v; r.fs = fs; r.b = b; r.rdy = rdy;
        r.ev = ev; r.ed = ed; r.eo = eo; r.eb = eb;
        tbl.push_back(r);
    endtask

    // Eight consecutive beats of word w; body_* is what the output port should
    // show during beats 1..7, end_* after the completing beat.
    task automatic add_frame(input logic [7:0] w, input logic rdy_body, rdy_last,
                             input logic body_v, input logic [7:0] body_d,
                             input logic end_v, input logic [7:0] end_d, input logic end_o);
        for (int i = 0; i < 7; i++)
            add(1'b1, (i == 0), w[i], rdy_body, body_v, body_d, 1'b0, 1'b1);
        add(1'b1, 1'b0, w[7], rdy_last, end_v, end_d, end_o, 1'b0);
    endtask

    task automatic drive(input logic v, fs, b, rdy);
        bus.in_valid    = v;
        bus.frame_start = fs;
        bus.in_bit      = b;
        bus.out_ready   = rdy;
    endtask

    task automatic beat(input logic v, fs, b);
        bus.in_valid    = v;
        bus.frame_start = fs;
        bus.in_bit      = b;
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [7:0] ed,
                           input logic eo, input logic eb);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
        chk({tag, ".out_data"},  32'(bus.out_data),  32'(ed));
        chk({tag, ".overrun"},   32'(bus.overrun),   32'(eo));
        chk({tag, ".busy"},      32'(bus.busy),      32'(eb));
    endtask

    logic [7:0] w;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Test 1: async reset
        #1 rst_n = 1'b0;
        #2 chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 2: 8'h4D, consumer ready
        add_frame(8'h4D, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h4D, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0);
        // Test 3: held 4D, all-ones frame overruns, then drain
        add_frame(8'h4D, 1'b0, 1'b0, 1'b0, 8'h4D, 1'b1, 8'h4D, 1'b0);
        add_frame(8'hFF, 1'b0, 1'b0, 1'b1, 8'h4D, 1'b1, 8'h4D, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h4D, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0);
        // Test 4: held word consumed on the same edge A5 completes
        add_frame(8'h4D, 1'b0, 1'b0, 1'b0, 8'h4D, 1'b1, 8'h4D, 1'b0);
        add_frame(8'hA5, 1'b0, 1'b1, 1'b1, 8'h4D, 1'b1, 8'hA5, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].fs, tbl[i].b, tbl[i].rdy);
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].eo, tbl[i].eb);
        end

        // Test 5: restart on beat 5, then 3C with random gaps
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        beat(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 1'b1);
        w = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            int gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) beat(1'b0, 1'b0, 1'b0);
            beat(1'b1, (i == 0), w[i]);
            if (i == 0) chk_out("restart", 1'b0, 8'hA5, 1'b0, 1'b1);
        end
        chk_out("restart_done", 1'b1, 8'h3C, 1'b0, 1'b0);

        // Test 6: held word and partial frame wiped by reset, then 8'h81
        bus.out_ready = 1'b0;
        beat(1'b0, 1'b0, 1'b0);
        chk("hold.out_valid", 32'(bus.out_valid), 32'd1);
        beat(1'b1, 1'b1, 1'b1);
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_out("midreset", 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        w = 8'h81;
        for (int i = 0; i < 8; i++) beat(1'b1, (i == 0), w[i]);
        chk_out("after_reset", 1'b1, 8'h81, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 1'b0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            chk("rnd.out_valid", 32'(bus.out_valid), 32'(m.wv));
            chk("rnd.out_data",  32'(bus.out_data),  32'(m.word));
            chk("rnd.overrun",   32'(bus.overrun),   32'(m.ovr));
            chk("rnd.busy",      32'(bus.busy),      32'(m.cnt > 0));
            drive(($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 15) == 0),
                  1'($urandom),
                  1'($urandom));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
